// File: rtl/ehxplll_pkg.sv
// Shared types and string constants for the behavioural EHXPLLL model.
package ehxplll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } lock_state_e;

    localparam string STR_ENABLED  = "ENABLED";
    localparam string STR_DISABLED = "DISABLED";
    localparam string STR_INT_OP   = "INT_OP";

endpackage

// File: rtl/ehxplll_ref_detect.sv
// Reference-activity detector: CLKI divide-and-toggle, 2-FF synchronizer into clk_4MHz,
// and a saturating silence counter that flags the reference as present or lost.
module ehxplll_ref_detect
    import ehxplll_pkg::*;
#(
    parameter int CLKI_DIV   = 6,
    parameter int ACT_WINDOW = 8
) (
    input  logic i_clki,
    input  logic clk_4MHz,
    input  logic rst,
    output logic o_ref_ok
);

    localparam int DW = (CLKI_DIV > 1) ? $clog2(CLKI_DIV) : 1;
    localparam int AW = $clog2(ACT_WINDOW + 1);

    // CLKI domain has no reset; the toggle only has to start moving.
    logic [DW-1:0] r_div_cnt = '0;
    logic          r_ref_tgl = 1'b0;

    always_ff @(posedge i_clki) begin
        if (r_div_cnt == DW'(CLKI_DIV - 1)) begin
            r_div_cnt <= '0;
            r_ref_tgl <= ~r_ref_tgl;
        end else begin
            r_div_cnt <= r_div_cnt + DW'(1);
        end
    end

    logic [1:0]    r_sync    = '0;
    logic [AW-1:0] r_act_cnt = AW'(ACT_WINDOW);
    logic          w_edge;

    assign w_edge = r_sync[1] ^ r_sync[0];

    always_ff @(posedge clk_4MHz) begin
        if (rst) begin
            r_sync    <= '0;
            r_act_cnt <= AW'(ACT_WINDOW);
        end else begin
            r_sync <= {r_sync[0], r_ref_tgl};
            if (w_edge)
                r_act_cnt <= '0;
            else if (r_act_cnt != AW'(ACT_WINDOW))
                r_act_cnt <= r_act_cnt + AW'(1);
        end
    end

    assign o_ref_ok = (r_act_cnt < AW'(ACT_WINDOW));

endmodule

// File: rtl/ehxplll.sv
// Behavioural stand-in for the ECP5 EHXPLLL: lock FSM driven by reference activity and
// standby, plus a negedge-registered gate that keeps CLKOP free of runt pulses.
module ehxplll
    import ehxplll_pkg::*;
#(
    parameter int    CLKI_DIV        = 6,
    parameter int    CLKFB_DIV       = 1,
    parameter int    CLKOP_DIV       = 128,
    parameter int    CLKOP_CPHASE    = 64,
    parameter int    CLKOP_FPHASE    = 0,
    parameter string CLKOP_ENABLE    = "ENABLED",
    parameter string FEEDBK_PATH     = "INT_OP",
    parameter string STDBY_ENABLE    = "DISABLED",
    parameter string PLLRST_ENA      = "DISABLED",
    parameter string INTFB_WAKE      = "DISABLED",
    parameter string DPHASE_SOURCE   = "DISABLED",
    parameter string OUTDIVIDER_MUXA = "DIVA",
    parameter string OUTDIVIDER_MUXB = "DIVB",
    parameter string OUTDIVIDER_MUXC = "DIVC",
    parameter string OUTDIVIDER_MUXD = "DIVD",
    parameter int    LOCK_CYCLES     = 16,
    parameter int    ACT_WINDOW      = 8
) (
    input  logic clk_4MHz,
    input  logic rst,
    input  logic CLKI,
    input  logic STDBY,
    input  logic CLKFB,
    input  logic PHASESEL0,
    input  logic PHASESEL1,
    input  logic PHASEDIR,
    input  logic PHASESTEP,
    input  logic PHASELOADREG,
    input  logic PLLWAKESYNC,
    input  logic ENCLKOP,
    output logic CLKOP,
    output logic CLKINTFB,
    output logic LOCK
);

    localparam int LW       = $clog2(LOCK_CYCLES + 1);
    localparam bit OUT_FREE = (CLKOP_ENABLE == STR_ENABLED);
    localparam bit FB_INT   = (FEEDBK_PATH == STR_INT_OP);
    localparam bit STBY_EN  = (STDBY_ENABLE == STR_ENABLED);

    logic w_ref_ok;
    logic w_stby_force;
    logic w_gate_en;
    logic w_unused;

    ehxplll_ref_detect #(
        .CLKI_DIV   (CLKI_DIV),
        .ACT_WINDOW (ACT_WINDOW)
    ) u_ref_detect (
        .i_clki   (CLKI),
        .clk_4MHz (clk_4MHz),
        .rst      (rst),
        .o_ref_ok (w_ref_ok)
    );

    assign w_stby_force = STBY_EN && STDBY;
    assign w_unused = ^{CLKFB, PHASESEL0, PHASESEL1, PHASEDIR, PHASESTEP,
                        PHASELOADREG, PLLWAKESYNC};

    lock_state_e r_state    = ST_IDLE;
    lock_state_e w_state_nxt;
    logic [LW-1:0] r_lock_cnt = '0;
    logic [LW-1:0] w_lock_cnt_nxt;
    logic          r_lock     = 1'b0;
    logic          r_gate     = 1'b0;

    always_ff @(posedge clk_4MHz) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_lock_cnt <= '0;
            r_lock     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_lock     <= (r_state == ST_LOCKED);
        end
    end

    // Loss of reference and standby share one exit path, so both together give one transition.
    always_comb begin
        w_state_nxt    = r_state;
        w_lock_cnt_nxt = r_lock_cnt;
        case (r_state)
            ST_IDLE: begin
                w_lock_cnt_nxt = '0;
                if (w_ref_ok && !w_stby_force)
                    w_state_nxt = ST_ACQ;
            end
            ST_ACQ: begin
                if (!w_ref_ok || w_stby_force) begin
                    w_state_nxt    = ST_IDLE;
                    w_lock_cnt_nxt = '0;
                end else begin
                    w_lock_cnt_nxt = r_lock_cnt + LW'(1);
                    if (r_lock_cnt == LW'(LOCK_CYCLES - 1))
                        w_state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (!w_ref_ok || w_stby_force) begin
                    w_state_nxt    = ST_IDLE;
                    w_lock_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_lock_cnt_nxt = '0;
            end
        endcase
    end

    assign w_gate_en = r_lock && (OUT_FREE || ENCLKOP);

    // Gate moves only while clk_4MHz is low, so CLKOP never emits a partial high phase.
    always_ff @(negedge clk_4MHz) begin
        if (rst)
            r_gate <= 1'b0;
        else
            r_gate <= w_gate_en;
    end

    assign CLKOP    = clk_4MHz & r_gate;
    assign CLKINTFB = FB_INT ? CLKOP : 1'b0;
    assign LOCK     = r_lock;

endmodule

// File: tb/tb_ehxplll.sv
// Directed bench for ehxplll: one default instance and one with standby enabled,
// CLKOP dynamically enabled and external feedback selected.
module tb_ehxplll;

    localparam int LC = 16;
    localparam int AWIN = 8;

    logic clk = 1'b0;
    logic clki = 1'b0;
    logic clki_run = 1'b1;
    logic rst = 1'b1;
    logic stdby0 = 1'b0, stdby1 = 1'b0, en1 = 1'b0;
    logic zero = 1'b0;
    logic clkop0, fb0, lock0, clkop1, fb1, lock1;
    logic g0, g1;

    int n_tests = 0;
    int n_fail  = 0;

    always #120 clk = ~clk;

    initial begin
        #7;
        forever begin
            #20;
            if (clki_run) clki = ~clki;
        end
    end

    ehxplll #(
        .LOCK_CYCLES (LC),
        .ACT_WINDOW  (AWIN)
    ) u0 (
        .clk_4MHz (clk), .rst (rst), .CLKI (clki), .STDBY (stdby0), .CLKFB (clkop0),
        .PHASESEL0 (zero), .PHASESEL1 (zero), .PHASEDIR (zero), .PHASESTEP (zero),
        .PHASELOADREG (zero), .PLLWAKESYNC (zero), .ENCLKOP (zero),
        .CLKOP (clkop0), .CLKINTFB (fb0), .LOCK (lock0)
    );

    ehxplll #(
        .CLKOP_ENABLE ("DISABLED"),
        .FEEDBK_PATH  ("CLKOP"),
        .STDBY_ENABLE ("ENABLED"),
        .LOCK_CYCLES  (LC),
        .ACT_WINDOW   (AWIN)
    ) u1 (
        .clk_4MHz (clk), .rst (rst), .CLKI (clki), .STDBY (stdby1), .CLKFB (zero),
        .PHASESEL0 (zero), .PHASESEL1 (zero), .PHASEDIR (zero), .PHASESTEP (zero),
        .PHASELOADREG (zero), .PLLWAKESYNC (zero), .ENCLKOP (en1),
        .CLKOP (clkop1), .CLKINTFB (fb1), .LOCK (lock1)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // CLKOP edges must coincide with clk_4MHz edges of the same direction.
    always @(posedge clkop0) begin
        n_tests++;
        assert (clk === 1'b1) else begin
            n_fail++;
            $error("FAIL clkop0_rise: clk observed %0b expected 1", clk);
        end
    end
    always @(negedge clkop0) begin
        n_tests++;
        assert (clk === 1'b0) else begin
            n_fail++;
            $error("FAIL clkop0_fall: clk observed %0b expected 0", clk);
        end
    end
    always @(posedge clkop1) begin
        n_tests++;
        assert (clk === 1'b1) else begin
            n_fail++;
            $error("FAIL clkop1_rise: clk observed %0b expected 1", clk);
        end
    end

    // One clock period: low-phase sample, then high-phase sample checked against the gate model.
    task automatic tick();
        @(negedge clk); #1;
        g0 = lock0 && !rst;
        g1 = lock1 && en1 && !rst;
        chk("clkop0_low", clkop0, 0);
        chk("clkop1_low", clkop1, 0);
        @(posedge clk); #1;
        chk("clkop0_gate", clkop0, g0);
        chk("clkop1_gate", clkop1, g1);
        chk("clkintfb0_int", fb0, clkop0);
        chk("clkintfb1_ext", fb1, 0);
    endtask

    initial begin
        int n;
        int got;

        tick();
        tick();
        chk("rst_lock0", lock0, 0);
        chk("rst_lock1", lock1, 0);
        chk("rst_lockcnt1", u1.r_lock_cnt, 0);
        rst = 1'b0;

        n = 0;
        got = 0;
        for (int i = 1; i <= 40 && got == 0; i++) begin
            tick();
            if (lock0) begin
                got = 1;
                n = i;
            end
        end
        chk("lock0_acquired", got, 1);
        chk("lock0_latency_ok", int'(n >= LC + 1 && n <= LC + 6), 1);
        chk("lock1_acquired", lock1, 1);
        for (int i = 0; i < 3; i++) tick();

        stdby0 = 1'b1;
        stdby1 = 1'b1;
        tick();
        tick();
        chk("stby_lock1_drop", lock1, 0);
        for (int i = 0; i < 3; i++) tick();
        chk("stby_ignored_lock0", lock0, 1);
        chk("stby_held_lock1", lock1, 0);
        stdby0 = 1'b0;
        stdby1 = 1'b0;
        for (int i = 0; i < LC + 1; i++) tick();
        chk("relock1_not_yet", lock1, 0);
        tick();
        chk("relock1_done", lock1, 1);

        tick();
        tick();
        en1 = 1'b1;
        #1;
        chk("enclkop_no_runt", clkop1, 0);
        tick();
        chk("enclkop_running", clkop1, 1);
        en1 = 1'b0;
        #1;
        chk("enclkop_full_high", clkop1, 1);
        tick();
        chk("enclkop_stopped", clkop1, 0);

        clki_run = 1'b0;
        n = 0;
        got = 0;
        for (int i = 1; i <= AWIN + 4 && got == 0; i++) begin
            tick();
            if (!lock0) begin
                got = 1;
                n = i;
            end
        end
        chk("refloss_lock0_drop", got, 1);
        chk("refloss_not_early", int'(n > AWIN), 1);
        chk("refloss_lock1_drop", lock1, 0);
        tick();
        tick();
        chk("refloss_clkop0_held", clkop0, 0);

        clki_run = 1'b1;
        got = 0;
        for (int i = 1; i <= 40 && got == 0; i++) begin
            tick();
            if (lock1) got = 1;
        end
        chk("refback_lock1", got, 1);
        stdby1 = 1'b1;
        tick();
        tick();
        stdby1 = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("midacq_lockcnt8", u1.r_lock_cnt, 8);
        rst = 1'b1;
        tick();
        chk("midacq_rst_lockcnt", u1.r_lock_cnt, 0);
        chk("midacq_rst_lock1", lock1, 0);
        rst = 1'b0;
        n = 0;
        got = 0;
        for (int i = 1; i <= 40 && got == 0; i++) begin
            tick();
            if (lock1) begin
                got = 1;
                n = i;
            end
        end
        chk("postrst_lock1", got, 1);
        chk("postrst_full_acq", int'(n >= LC + 1 && n <= LC + 6), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
